// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit timing.
// Imported by uart_rx and uart_sync2.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t S_IDLE      = 3'd0;
  localparam uart_state_t S_START     = 3'd1;
  localparam uart_state_t S_DATA      = 3'd2;
  localparam uart_state_t S_PARITY    = 3'd3;
  localparam uart_state_t S_STOP      = 3'd4;
  localparam uart_state_t S_WAIT_IDLE = 3'd5;

  localparam int TICKS_PER_BIT = 4;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for the async rx line.
// Both flops reset to 1 (line idle level).
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture, reset to idle-high
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 4 ticks/bit, mid-bit sampling.
// Define UART_RX_PARITY_EN for an even-parity bit after bit 7.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] rx_byte,
  output logic       data_valid,
  output logic       received,
  output logic       is_receiving,
  output logic       recv_error,
  output logic       overrun
);

  localparam int CLOCK_DIVIDE =
    CLOCK_FREQUENCY / (BAUD_RATE * TICKS_PER_BIT);
  localparam int DW =
    (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDE - 1);
  localparam logic [1:0] T_LAST = 2'(TICKS_PER_BIT - 1);
  localparam logic [1:0] T_MID  = 2'(TICKS_PER_BIT / 2 - 1);

  uart_state_t   state;
  logic          rx_s;
  logic          rx_d;
  logic          fall;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          stop_smp;
  logic          par_ok;
  logic          frame_good;
  logic          frame_bad;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign fall = rx_d & ~rx_s;
  assign tick = (div_cnt == DIV_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  assign stop_smp   = (state == S_STOP) && tick &&
                      (tick_cnt == T_LAST);
  assign frame_good = stop_smp && rx_s && par_ok;
  assign frame_bad  = stop_smp && !(rx_s && par_ok);

  assign is_receiving = (state != S_IDLE);

  // delayed copy of the synchronized line for edge detect
  always_ff @(posedge clk) begin
    if (!rst) rx_d <= 1'b1;
    else      rx_d <= rx_s;
  end

  // free-running tick divider, re-phased on a start edge
  always_ff @(posedge clk) begin
    if (!rst)
      div_cnt <= '0;
    else if ((state == S_IDLE && fall) || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DW'(1);
  end

  // frame FSM: bit timing, shifting and stop handling
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      tick_cnt <= 2'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (fall) begin
            state    <= S_START;
            tick_cnt <= 2'd0;
          end
        end
        S_START: begin
          if (tick) begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= 2'd0;
              bit_cnt  <= 3'd0;
              state    <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 2'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 2'd1;
            if (tick_cnt == T_LAST) begin
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 2'd1;
            if (tick_cnt == T_LAST) begin
              par_bit <= rx_s;
              state   <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 2'd1;
            if (tick_cnt == T_LAST)
              state <= rx_s ? S_IDLE : S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (!rx_s) begin
            tick_cnt <= 2'd0;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 2'd1;
            if (tick_cnt == T_LAST)
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // holding register, status pulses and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_byte    <= 8'h00;
      data_valid <= 1'b0;
      received   <= 1'b0;
      recv_error <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      received   <= 1'b0;
      recv_error <= frame_bad;
      if (frame_good) begin
        if (data_valid && !rd) begin
          overrun <= 1'b1;
        end else begin
          rx_byte    <= shreg;
          data_valid <= 1'b1;
          received   <= 1'b1;
        end
      end else if (rd) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
